// File: rtl/note_seq_pkg.sv
// note_seq_pkg: shared state encodings, entry field widths and default tick divider for the note sequencer
package note_seq_pkg;
    typedef enum logic [1:0] {IDLE, HOLD, PLAY} state_t;
    typedef enum logic [1:0] {P_READ, P_LOAD, P_TONE} phase_t;
    localparam int NOTE_W = 4;
    localparam int OCT_W = 2;
    localparam int DUR_W = 4;
    localparam int ENTRY_W = NOTE_W + OCT_W + DUR_W;
    localparam int TICK_DIV_DEFAULT = 12_500_000;
endpackage

// File: rtl/note_seq_mem.sv
// note_seq_mem: DEPTH x W single-port RAM, synchronous write, registered read with enable
// Ports: clk, reset (async active-low, clears only the read register), we/wdata write at addr,
//        re loads rdata from addr on the next edge; rdata holds between reads.
module note_seq_mem
    import note_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int W = ENTRY_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     we,
    input  logic                     re,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [W-1:0]             wdata,
    output logic [W-1:0]             rdata
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;

    always_ff @(posedge clk or negedge reset)
        if (!reset) rdata <= '0;
        else if (re) rdata <= mem[addr];
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: record/playback controller for key presses feeding the note datapath
// Ports: clk, reset (async active-low); rec_make/rec_break/rec_note/rec_octave from keyboard decode;
//        play_req/stop_req/clear_req control pulses; note_out/octave_out/ld_note/ld_play to datapath;
//        count = stored entries, busy = not IDLE, done = one-cycle end-of-playback pulse.
module note_sequencer
    import note_seq_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int TICK_DIV = TICK_DIV_DEFAULT,
    parameter int MAX_TICKS = 15
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rec_make,
    input  logic                     rec_break,
    input  logic [NOTE_W-1:0]        rec_note,
    input  logic [OCT_W-1:0]         rec_octave,
    input  logic                     play_req,
    input  logic                     stop_req,
    input  logic                     clear_req,
    output logic [NOTE_W-1:0]        note_out,
    output logic [OCT_W-1:0]         octave_out,
    output logic                     ld_note,
    output logic                     ld_play,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     busy,
    output logic                     done
);
    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TICK_DIV + 1);
    localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [DUR_W-1:0] DUR_SAT = DUR_W'(MAX_TICKS - 1);

    state_t              state;
    phase_t              phase;
    logic [TW-1:0]       tick;
    logic [DUR_W-1:0]    dur;
    logic [AW-1:0]       idx;
    logic [NOTE_W-1:0]   note_l;
    logic [OCT_W-1:0]    oct_l;
    logic [ENTRY_W-1:0]  rdata;
    logic [DUR_W-1:0]    rd_dur;
    logic                tick_wrap;
    logic                we;
    logic                re;
    logic [AW-1:0]       addr;

    assign tick_wrap  = tick == TICK_LAST;
    assign we         = state == HOLD && rec_break;
    assign re         = state == PLAY && phase == P_READ;
    assign addr       = state == HOLD ? count[AW-1:0] : idx;
    // The RAM read register doubles as the note/octave output register, so the
    // loaded values stay valid through the tone and after playback ends.
    assign note_out   = rdata[ENTRY_W-1 -: NOTE_W];
    assign octave_out = rdata[DUR_W +: OCT_W];
    assign rd_dur     = rdata[DUR_W-1:0];
    assign busy       = state != IDLE;

    note_seq_mem #(.DEPTH(DEPTH), .W(ENTRY_W)) u_mem (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .re    (re),
        .addr  (addr),
        .wdata ({note_l, oct_l, dur + DUR_W'(1)}),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            phase   <= P_READ;
            count   <= '0;
            tick    <= '0;
            dur     <= '0;
            idx     <= '0;
            note_l  <= '0;
            oct_l   <= '0;
            ld_note <= 1'b0;
            ld_play <= 1'b0;
            done    <= 1'b0;
        end else begin
            done    <= 1'b0;
            ld_note <= 1'b0;
            case (state)
                IDLE: begin
                    if (clear_req) count <= '0;
                    else if (rec_make && count != FULL) begin
                        state  <= HOLD;
                        note_l <= rec_note;
                        oct_l  <= rec_octave;
                        tick   <= '0;
                        dur    <= '0;
                    end else if (play_req && count != '0) begin
                        state <= PLAY;
                        phase <= P_READ;
                        idx   <= '0;
                    end
                end
                HOLD: begin
                    if (rec_break) begin
                        count <= count + 1'b1;
                        state <= IDLE;
                    end else begin
                        tick <= tick_wrap ? '0 : tick + 1'b1;
                        if (tick_wrap && dur != DUR_SAT) dur <= dur + 1'b1;
                    end
                end
                PLAY: begin
                    if (stop_req) begin
                        state   <= IDLE;
                        ld_play <= 1'b0;
                    end else begin
                        case (phase)
                            P_READ: begin
                                phase   <= P_LOAD;
                                ld_note <= 1'b1;
                            end
                            P_LOAD: begin
                                phase   <= P_TONE;
                                ld_play <= 1'b1;
                                tick    <= '0;
                                dur     <= rd_dur;
                            end
                            P_TONE: begin
                                tick <= tick_wrap ? '0 : tick + 1'b1;
                                if (tick_wrap) begin
                                    dur <= dur - 1'b1;
                                    // dur counts down the remaining ticks of this entry
                                    if (dur <= DUR_W'(1)) begin
                                        ld_play <= 1'b0;
                                        if ({1'b0, idx} == count - 1'b1) begin
                                            state <= IDLE;
                                            done  <= 1'b1;
                                        end else begin
                                            idx   <= idx + 1'b1;
                                            phase <= P_READ;
                                        end
                                    end
                                end
                            end
                            default: phase <= P_READ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
